param_alu_seq: RTL and testbench
================================

PARAM_ALU_SEQ -- requirements
Module: param_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width per input (legal 2..16).
REQ-002 SHALL have clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have reset  input  1  synchronous active-high reset.
REQ-004 SHALL have in_valid  input  1  operation request.
REQ-005 SHALL have in_ready  output  1  block can accept an operation.
REQ-006 SHALL have a, b  input  WIDTH each  unsigned operands.
REQ-007 SHALL have opcode  input  4  operation select.
REQ-008 SHALL have out_valid  output  1  result available.
REQ-009 SHALL have out_ready  input  1  consumer accepts result.
REQ-010 SHALL have result  output  2*WIDTH  registered result.
REQ-011 SHALL have carry  output  1  carry/borrow/wrap flag.
REQ-012 SHALL have zero  output  1  result equals 0.

Function
REQ-013 SHALL use FSM states IDLE, MUL, DONE; in_ready = (state==IDLE).
REQ-014 SHALL accept an operation when in_valid&&in_ready at a rising edge, capturing a, b, opcode.
REQ-015 SHALL, for opcodes other than 9, load result/flags at the accept edge and enter DONE (out_valid high next cycle).
REQ-016 SHALL implement 0 AND, 1 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR on WIDTH bits, zero-extended.
REQ-017 SHALL implement opcode 2 NOT as {~a,~b}.
REQ-018 SHALL implement 7 ADD as a+b in WIDTH+1 bits zero-extended; carry = bit WIDTH.
REQ-019 SHALL implement 8 SUB as (a-b) mod 2^(WIDTH+1) zero-extended; carry = borrow (a<b).
REQ-020 SHALL implement 9 MUL as sequential shift-add: enter MUL, exactly WIDTH cycles in MUL, then DONE; out_valid rises WIDTH+1 cycles after accept; result = a*b full 2*WIDTH; carry=0.
REQ-021 SHALL implement 10 CMP: result 2'b10 a>b, 2'b01 a<b, 2'b11 equal, zero-extended.
REQ-022 SHALL implement 11 SLL and 13 SLA as {a,b}<<1; 12 SRL as {a,b}>>1 with zero fill; 14 SRA as {a,b}>>1 replicating bit 2*WIDTH-1; carry = bit shifted out.
REQ-023 SHALL implement 15 ACC: internal 2*WIDTH accumulator acc <= acc+{a,b}; result = new acc; carry = overflow of that add.
REQ-024 SHALL compute zero from the loaded result; carry SHALL be 0 for opcodes not listed as setting it.
REQ-025 SHALL hold result, carry, zero, out_valid stable in DONE while out_ready low.
REQ-026 SHALL leave DONE for IDLE on the edge where out_valid&&out_ready; no new accept in that same cycle.
REQ-027 SHALL retain acc across operations; only ACC and reset modify it.
REQ-028 SHALL keep in_ready low during MUL and DONE; in_valid ignored there.

Reset
REQ-029 SHALL on reset force state IDLE, out_valid 0, result 0, carry 0, zero 0, acc 0.
REQ-030 SHALL abort an in-progress MUL or pending DONE result on reset, discarding it; reset has priority over all other events.
REQ-031 SHALL present in_ready 1 on the first cycle after reset deasserts.

Configuration
REQ-032 SHALL honour macro PARAM_ALU_ACC_SAT_EN: defined -> ACC saturates at all-ones on overflow (carry=1, acc stays all-ones); undefined -> ACC wraps modulo 2^(2*WIDTH) with carry=1.

Verification (WIDTH=4)
REQ-033 SHALL cover ADD a=15,b=15 -> result 0x1E, carry 1, zero 0, out_valid one cycle after accept.
REQ-034 SHALL cover SUB a=3,b=5 -> result 0x1E, carry 1; SUB a=5,b=5 -> result 0, zero 1.
REQ-035 SHALL cover MUL a=15,b=13 -> result 0xC3, out_valid exactly 5 cycles after accept, in_ready 0 throughout.
REQ-036 SHALL cover ACC {a,b}=0xFF twice from reset -> 0xFF carry 0, then 0xFE carry 1 (wrap) or 0xFF carry 1 with PARAM_ALU_ACC_SAT_EN.
REQ-037 SHALL cover out_ready held low 10 cycles after CMP a=2,b=1 -> result 2'b10 stable, in_ready 0; release -> IDLE next edge.
REQ-038 SHALL cover reset asserted 2 cycles into MUL -> out_valid never asserts, acc 0, in_ready 1 after reset release.

Source files
------------

// File: rtl/param_alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift/compare/accumulate ops, a shift-add multiplier,
// and a valid/ready result port. Define PARAM_ALU_ACC_SAT_EN for a saturating accumulator.
module param_alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 zero,
    output logic [1:0]           state_dbg
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready. Valid
    // sources hold their payload stable until the transfer edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [RW-1:0]    acc;
    logic [RW-1:0]    mcand;
    logic [RW-1:0]    prod;
    logic [RW-1:0]    prod_step;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic [RW-1:0]    cat;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_d;
    logic [RW:0]      acc_sum;
    logic [RW-1:0]    alu_res;
    logic             alu_carry;
    logic [RW-1:0]    acc_next;
    logic [1:0]       cmp;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (opcode == 4'd9) ? MUL : DONE;
            MUL:  if (cnt == CNT_LAST) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cat       = {a, b};
        add_s     = {1'b0, a} + {1'b0, b};
        sub_d     = {1'b0, a} - {1'b0, b};
        acc_sum   = {1'b0, acc} + {1'b0, cat};
        cmp       = (a > b) ? 2'b10 : ((a < b) ? 2'b01 : 2'b11);
        alu_res   = '0;
        alu_carry = 1'b0;
        acc_next  = acc;
        case (opcode)
            4'd0:  alu_res = {{WIDTH{1'b0}}, a & b};
            4'd1:  alu_res = {{WIDTH{1'b0}}, a | b};
            4'd2:  alu_res = {~a, ~b};
            4'd3:  alu_res = {{WIDTH{1'b0}}, a ^ b};
            4'd4:  alu_res = {{WIDTH{1'b0}}, ~(a & b)};
            4'd5:  alu_res = {{WIDTH{1'b0}}, ~(a | b)};
            4'd6:  alu_res = {{WIDTH{1'b0}}, ~(a ^ b)};
            4'd7: begin
                alu_res   = {{(WIDTH-1){1'b0}}, add_s};
                alu_carry = add_s[WIDTH];
            end
            4'd8: begin
                // The top bit of a WIDTH+1 bit difference is exactly the borrow a < b.
                alu_res   = {{(WIDTH-1){1'b0}}, sub_d};
                alu_carry = sub_d[WIDTH];
            end
            4'd10: alu_res = {{(RW-2){1'b0}}, cmp};
            4'd11, 4'd13: begin
                alu_res   = {cat[RW-2:0], 1'b0};
                alu_carry = cat[RW-1];
            end
            4'd12: begin
                alu_res   = {1'b0, cat[RW-1:1]};
                alu_carry = cat[0];
            end
            4'd14: begin
                alu_res   = {cat[RW-1], cat[RW-1:1]};
                alu_carry = cat[0];
            end
            4'd15: begin
`ifdef PARAM_ALU_ACC_SAT_EN
                acc_next = acc_sum[RW] ? {RW{1'b1}} : acc_sum[RW-1:0];
`else
                acc_next = acc_sum[RW-1:0];
`endif
                alu_res   = acc_next;
                alu_carry = acc_sum[RW];
            end
            default: ;
        endcase
    end

    always_comb begin
        prod_step = prod + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (opcode == 4'd9) begin
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            prod   <= '0;
                            cnt    <= '0;
                        end else begin
                            result <= alu_res;
                            carry  <= alu_carry;
                            zero   <= (alu_res == '0);
                            acc    <= acc_next;
                        end
                    end
                end
                MUL: begin
                    // One multiplier bit per cycle; the last step lands straight in result.
                    prod   <= prod_step;
                    mcand  <= {mcand[RW-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        result <= prod_step;
                        carry  <= 1'b0;
                        zero   <= (prod_step == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu_seq.sv
// Directed bench for param_alu_seq (WIDTH=4): drivers push expected {result,carry,zero}
// into exp_q and a monitor pops and compares on every result transfer.
module tb_param_alu_seq;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    opcode;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          carry;
    logic          zero;
    logic [1:0]    state_dbg;

    logic [RW+1:0] exp_q[$];
    logic [RW+1:0] exp_e;
    int            n_vec  = 0;
    int            n_miss = 0;

    param_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_output: got result 0x%0h with nothing expected", result);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("result", 32'(result), 32'(exp_e[RW+1:2]));
                    check("carry",  32'(carry),  32'(exp_e[1]));
                    check("zero",   32'(zero),   32'(exp_e[0]));
                end
            end
        end
    end

    // drivers
    task automatic wait_ready();
        for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge clk);
        if (in_ready !== 1'b1) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [RW-1:0] er, input logic ec, input logic ez, input int exp_lat);
        int  lat;
        bit  seen;
        wait_ready();
        a        = ta;
        b        = tb_v;
        opcode   = op;
        in_valid = 1'b1;
        exp_q.push_back({er, ec, ez});
        @(posedge clk);
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            check("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_valid === 1'b1) seen = 1;
        end
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_carry",     32'(carry),     32'd0);
        check("rst_zero",      32'(zero),      32'd0);
        check("rst_state",     32'(state_dbg), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // accumulator from reset
        do_op(4'd15, 4'hF, 4'hF, 8'hFF, 1'b1 ^ 1'b1, 1'b0, 1);
`ifdef PARAM_ALU_ACC_SAT_EN
        do_op(4'd15, 4'hF, 4'hF, 8'hFF, 1'b1, 1'b0, 1);
`else
        do_op(4'd15, 4'hF, 4'hF, 8'hFE, 1'b1, 1'b0, 1);
`endif

        // arithmetic
        do_op(4'd7,  4'd15, 4'd15, 8'h1E, 1'b1, 1'b0, 1);
        do_op(4'd8,  4'd3,  4'd5,  8'h1E, 1'b1, 1'b0, 1);
        do_op(4'd8,  4'd5,  4'd5,  8'h00, 1'b0, 1'b1, 1);
        do_op(4'd7,  4'd2,  4'd3,  8'h05, 1'b0, 1'b0, 1);

        // logic, a=C b=A
        do_op(4'd0,  4'hC, 4'hA, 8'h08, 1'b0, 1'b0, 1);
        do_op(4'd1,  4'hC, 4'hA, 8'h0E, 1'b0, 1'b0, 1);
        do_op(4'd2,  4'hC, 4'hA, 8'h35, 1'b0, 1'b0, 1);
        do_op(4'd3,  4'hC, 4'hA, 8'h06, 1'b0, 1'b0, 1);
        do_op(4'd4,  4'hC, 4'hA, 8'h07, 1'b0, 1'b0, 1);
        do_op(4'd5,  4'hC, 4'hA, 8'h01, 1'b0, 1'b0, 1);
        do_op(4'd6,  4'hC, 4'hA, 8'h09, 1'b0, 1'b0, 1);

        // multiply
        do_op(4'd9,  4'd15, 4'd13, 8'hC3, 1'b0, 1'b0, 5);
        do_op(4'd9,  4'd0,  4'd7,  8'h00, 1'b0, 1'b1, 5);
        do_op(4'd9,  4'd6,  4'd5,  8'h1E, 1'b0, 1'b0, 5);

        // compare
        do_op(4'd10, 4'd1, 4'd2, 8'h01, 1'b0, 1'b0, 1);
        do_op(4'd10, 4'd7, 4'd7, 8'h03, 1'b0, 1'b0, 1);

        // shifts on {a,b}=0x91
        do_op(4'd11, 4'h9, 4'h1, 8'h22, 1'b1, 1'b0, 1);
        do_op(4'd13, 4'h9, 4'h1, 8'h22, 1'b1, 1'b0, 1);
        do_op(4'd12, 4'h9, 4'h1, 8'h48, 1'b1, 1'b0, 1);
        do_op(4'd14, 4'h9, 4'h1, 8'hC8, 1'b1, 1'b0, 1);
        do_op(4'd12, 4'h0, 4'h1, 8'h00, 1'b1, 1'b1, 1);
        do_op(4'd14, 4'h4, 4'h2, 8'h21, 1'b0, 1'b0, 1);
        wait_drain();

        // back-pressure: result held while out_ready is low, in_valid ignored
        out_ready = 1'b0;
        do_op(4'd10, 4'd2, 4'd1, 8'h02, 1'b0, 1'b0, 1);
        a        = 4'd1;
        b        = 4'd1;
        opcode   = 4'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid",  32'(out_valid), 32'd1);
            check("stall_result", 32'(result),    32'h02);
            check("stall_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_ready", 32'(in_ready),  32'd1);
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_state", 32'(state_dbg), 32'd0);
        in_valid = 1'b0;
        wait_drain();

        // reset in the middle of a multiply discards it
        wait_ready();
        a        = 4'd15;
        b        = 4'd13;
        opcode   = 4'd9;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mul_busy_state", 32'(state_dbg), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mulrst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("mulrst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mulrst_no_valid", 32'(out_valid), 32'd0);
        end
        do_op(4'd15, 4'h0, 4'h1, 8'h01, 1'b0, 1'b0, 1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
